br_resolve: RTL and testbench
=============================

BR_RESOLVE -- requirements
Module: br_resolve

Interface
REQ-001 Parameter XLEN, default 64, datapath width in bits.
REQ-002 Parameter BHT_DEPTH, default 64, number of 2-bit counters; power of two, at least 2.
REQ-003 Parameter IDX_W, default $clog2(BHT_DEPTH), BHT index width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  branch operands are valid this cycle.
REQ-007 in_ready  out  1  block can accept an operand set this cycle.
REQ-008 brsel  in  4  operation select: 0 none, 1 jal, 2 jalr, 3 beq, 4 bne, 5 blt, 6 bge, 7 bltu, 8 bgeu; 9-15 treated as 0.
REQ-009 rs1, rs2  in  XLEN  source operands.
REQ-010 pc, imm  in  XLEN  instruction PC and sign-extended immediate.
REQ-011 pred_taken, pred_target  in  1, XLEN  frontend prediction for this instruction.
REQ-012 out_valid  out  1  resolved result held in the output register.
REQ-013 out_ready  in  1  consumer accepts the result this cycle.
REQ-014 out_taken, out_target  out  1, XLEN  actual outcome and next PC.
REQ-015 out_mispredict  out  1  redirect required.
REQ-016 flush  in  1  kill the held result and block acceptance this cycle.
REQ-017 lookup_pc  in  XLEN, lookup_taken  out  1  combinational BHT prediction port.
REQ-018 mispredict_cnt  out  32  running count of delivered mispredicts.

Function
REQ-019 Accept occurs when in_valid and in_ready are both high; in_ready = !flush && (!out_valid || out_ready).
REQ-020 Latency is exactly one cycle: an operand set accepted at edge N drives out_valid high after edge N.
REQ-021 out_valid clears after an edge where out_valid && out_ready holds with no new accept, or where flush is high; on flush, the output fields keep their old values.
REQ-022 Taken rule: brsel 1 and 2 are always taken; brsel 3-8 are taken on eq, ne, signed lt, signed ge, unsigned lt, and unsigned ge; brsel 0 is never taken.
REQ-023 Target rule: brsel 2 uses (rs1+imm) with bit 0 forced to 0; brsel 1 and 3-8 use pc+imm; all sums are mod 2^XLEN.
REQ-024 out_target = taken ? target : pc+4, mod 2^XLEN.
REQ-025 out_mispredict = (taken != pred_taken) || (taken && target != pred_target); it is 0 for brsel 0.
REQ-026 out_taken, out_target and out_mispredict are registered on accept and are stable while out_valid && !out_ready.
REQ-027 BHT index = pc[IDX_W+1:2]; lookup index = lookup_pc[IDX_W+1:2].
REQ-028 lookup_taken = counter[lookup index] bit 1; a read in the same cycle as an update to that index returns the pre-update value.
REQ-029 BHT updates on accept for brsel 3-8 only: taken increments the counter, saturating at 3; not-taken decrements it, saturating at 0.
REQ-030 mispredict_cnt increments on each out_valid && out_ready && out_mispredict handshake and wraps from 2^32-1 to 0; flushed results are not counted.
REQ-031 Flush takes precedence over accept and over BHT update in the same cycle.

Reset
REQ-032 Reset forces out_valid=0, out_taken=0, out_target=0, out_mispredict=0, mispredict_cnt=0, and every BHT counter to 2'b01 (weakly not-taken).
REQ-033 Reset asserted mid-transaction discards the held result; in_ready is 0 while reset is high.

Verification
REQ-034 After reset, accept beq with rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=0 -> next cycle out_valid=1, out_taken=1, out_target=0x120, out_mispredict=1; lookup_pc=0x100 -> lookup_taken=1.
REQ-035 Accept jalr with rs1=0x1001, imm=0x10, pred_taken=1, pred_target=0x1010 -> out_target=0x1010, out_mispredict=0, BHT unchanged.
REQ-036 Hold out_ready=0 for 3 cycles with a second in_valid pending -> in_ready=0 and outputs stable; raise out_ready -> second result appears the following cycle; mispredict_cnt is correct.
REQ-037 Issue four taken beq at the same pc -> counter saturates at 3; then two not-taken -> counter=1, lookup_taken=0.
REQ-038 blt with rs1=-1, rs2=1 -> taken; bltu with the same values -> not taken, out_target=pc+4.
REQ-039 Assert flush together with out_valid and a new in_valid -> out_valid=0 next cycle, no BHT update, mispredict_cnt unchanged.

Source files
------------

// File: rtl/br_resolve_if.sv
// Operand and result channels of the branch resolve unit.
// The environment is the master and br_resolve is the slave.
interface br_resolve_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      brsel;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_target;
  logic            out_mispredict;

  modport master (
    output in_valid, brsel, rs1, rs2, pc, imm, pred_taken, pred_target, out_ready,
    input  in_ready, out_valid, out_taken, out_target, out_mispredict
  );

  modport slave (
    input  in_valid, brsel, rs1, rs2, pc, imm, pred_taken, pred_target, out_ready,
    output in_ready, out_valid, out_taken, out_target, out_mispredict
  );
endinterface

// File: rtl/br_resolve.sv
// Branch resolve unit: evaluates condition and next PC with one cycle of latency,
// trains a table of 2-bit counters and counts delivered mispredicts.
module br_resolve #(
  parameter int XLEN      = 64,
  parameter int BHT_DEPTH = 64,
  parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  br_resolve_if.slave     bus,
  input  logic            flush,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken,
  output logic [31:0]     mispredict_cnt
);
  logic [3:0]      sel;
  logic            taken;
  logic            is_cond;
  logic            mispredict;
  logic            accept;
  logic            deliver;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] look_idx;
  logic [1:0]      bht [BHT_DEPTH];
  logic            unused_lookup_bits;

  // Reserved select codes behave exactly like "no branch".
  assign sel     = (bus.brsel > 4'd8) ? 4'd0 : bus.brsel;
  assign is_cond = (sel >= 4'd3) && (sel <= 4'd8);

  always_comb begin
    taken = 1'b0;
    case (sel)
      4'd1, 4'd2: taken = 1'b1;
      4'd3:       taken = (bus.rs1 == bus.rs2);
      4'd4:       taken = (bus.rs1 != bus.rs2);
      4'd5:       taken = ($signed(bus.rs1) <  $signed(bus.rs2));
      4'd6:       taken = ($signed(bus.rs1) >= $signed(bus.rs2));
      4'd7:       taken = (bus.rs1 <  bus.rs2);
      4'd8:       taken = (bus.rs1 >= bus.rs2);
      default:    taken = 1'b0;
    endcase
  end

  assign jalr_sum   = bus.rs1 + bus.imm;
  assign target     = (sel == 4'd2) ? {jalr_sum[XLEN-1:1], 1'b0} : (bus.pc + bus.imm);
  assign next_pc    = taken ? target : (bus.pc + XLEN'(4));
  assign mispredict = (sel != 4'd0) &&
                      ((taken != bus.pred_taken) || (taken && (target != bus.pred_target)));

  assign bus.in_ready = !reset && !flush && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  // A flushed result is killed, so it never counts as delivered.
  assign deliver      = bus.out_valid && bus.out_ready && !flush;

  assign upd_idx      = bus.pc[IDX_W+1:2];
  assign look_idx     = lookup_pc[IDX_W+1:2];
  assign lookup_taken = bht[look_idx][1];
  assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid      <= 1'b0;
      bus.out_taken      <= 1'b0;
      bus.out_target     <= '0;
      bus.out_mispredict <= 1'b0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid      <= 1'b1;
      bus.out_taken      <= taken;
      bus.out_target     <= next_pc;
      bus.out_mispredict <= mispredict;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict_cnt <= '0;
    end else if (deliver && bus.out_mispredict) begin
      mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (accept && is_cond) begin
      if (taken && (bht[upd_idx] != 2'b11)) begin
        bht[upd_idx] <= bht[upd_idx] + 2'd1;
      end else if (!taken && (bht[upd_idx] != 2'b00)) begin
        bht[upd_idx] <= bht[upd_idx] - 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_br_resolve.sv
// Bench for br_resolve: constant vector table, directed multi-cycle sequences and
// random traffic checked against a cycle-level reference model.
module tb_br_resolve;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [63:0] lookup_pc = '0;
  logic        lookup_taken;
  logic [31:0] mispredict_cnt;

  br_resolve_if #(.XLEN(64)) bus ();

  br_resolve #(.XLEN(64), .BHT_DEPTH(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .flush          (flush),
    .lookup_pc      (lookup_pc),
    .lookup_taken   (lookup_taken),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic        m_valid, m_taken, m_mis;
  logic [63:0] m_target;
  logic [31:0] m_cnt;
  int          m_bht [64];

  typedef struct {
    logic [3:0]  sel;
    logic [63:0] a, b, pc, imm;
    logic        pt;
    logic [63:0] ptg;
    logic        et;
    logic [63:0] etg;
    logic        em;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic void resolve(input logic [3:0] s, input logic [63:0] a, b, pc, imm,
                                  input logic pt, input logic [63:0] ptg,
                                  output logic t, output logic [63:0] nxt, output logic mis);
    logic [63:0] tgt;
    case (s)
      4'd1, 4'd2: t = 1'b1;
      4'd3: t = (a == b);
      4'd4: t = (a != b);
      4'd5: t = ($signed(a) < $signed(b));
      4'd6: t = !($signed(a) < $signed(b));
      4'd7: t = (a < b);
      4'd8: t = !(a < b);
      default: t = 1'b0;
    endcase
    tgt = (s == 4'd2) ? ((a + imm) & 64'hFFFF_FFFF_FFFF_FFFE) : (pc + imm);
    nxt = t ? tgt : pc + 64'd4;
    mis = (s >= 4'd1 && s <= 4'd8) && ((t != pt) || (t && tgt != ptg));
  endfunction

  task automatic model_reset();
    m_valid = 0; m_taken = 0; m_mis = 0; m_target = '0; m_cnt = '0;
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
  endtask

  task automatic drive(input logic [3:0] s, input logic [63:0] a, b, pc, imm,
                       input logic pt, input logic [63:0] ptg);
    bus.brsel = s; bus.rs1 = a; bus.rs2 = b; bus.pc = pc; bus.imm = imm;
    bus.pred_taken = pt; bus.pred_target = ptg;
  endtask

  // One clock: check combinational outputs, advance the model, check registers.
  task automatic cycle();
    logic exp_ready, acc, t, mi;
    logic [63:0] nxt;
    logic [3:0] s;
    int ui;
    #1;
    exp_ready = !flush && (!m_valid || bus.out_ready);
    chk("in_ready", bus.in_ready, exp_ready);
    chk("lookup_taken", lookup_taken, (m_bht[lookup_pc[7:2]] >= 2));
    acc = bus.in_valid && exp_ready;
    s = bus.brsel;
    ui = bus.pc[7:2];
    resolve(bus.brsel, bus.rs1, bus.rs2, bus.pc, bus.imm, bus.pred_taken, bus.pred_target, t, nxt, mi);
    @(posedge clk);
    if (m_valid && bus.out_ready && m_mis && !flush) m_cnt = m_cnt + 1;
    if (flush) m_valid = 0;
    else if (acc) begin m_valid = 1; m_taken = t; m_target = nxt; m_mis = mi; end
    else if (bus.out_ready) m_valid = 0;
    if (acc && s >= 3 && s <= 8) begin
      if (t) m_bht[ui] = (m_bht[ui] == 3) ? 3 : m_bht[ui] + 1;
      else   m_bht[ui] = (m_bht[ui] == 0) ? 0 : m_bht[ui] - 1;
    end
    #1;
    chk("out_valid", bus.out_valid, m_valid);
    chk("out_taken", bus.out_taken, m_taken);
    chk("out_target", bus.out_target, m_target);
    chk("out_mispredict", bus.out_mispredict, m_mis);
    chk("mispredict_cnt", mispredict_cnt, m_cnt);
  endtask

  initial begin
    logic [31:0] saved_cnt;
    logic        saved_look;
    logic [63:0] a, b;

    vecs[0] = '{4'd4, 64'd1, 64'd2, 64'h200, 64'h40, 1'b1, 64'h240, 1'b1, 64'h240, 1'b0};
    vecs[1] = '{4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h300, 64'd8, 1'b0, 64'h0, 1'b1, 64'h308, 1'b1};
    vecs[2] = '{4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h300, 64'd8, 1'b0, 64'h0, 1'b0, 64'h304, 1'b0};
    vecs[3] = '{4'd6, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h400, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h3FC, 1'b1, 64'h3FC, 1'b0};
    vecs[4] = '{4'd8, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h400, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h3FC, 1'b0, 64'h404, 1'b1};
    vecs[5] = '{4'd1, 64'd0, 64'd0, 64'h500, 64'h100, 1'b1, 64'h700, 1'b1, 64'h600, 1'b1};
    vecs[6] = '{4'd0, 64'd0, 64'd0, 64'h500, 64'h100, 1'b1, 64'h600, 1'b0, 64'h504, 1'b0};
    vecs[7] = '{4'd12, 64'd7, 64'd7, 64'h500, 64'h100, 1'b1, 64'h600, 1'b0, 64'h504, 1'b0};
    vecs[8] = '{4'd3, 64'd3, 64'd4, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
    vecs[9] = '{4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h40, 64'd2, 1'b1, 64'h0, 1'b1, 64'h0, 1'b0};

    bus.in_valid = 0; bus.out_ready = 0;
    drive(4'd0, '0, '0, '0, '0, 1'b0, '0);
    model_reset();
    #12;
    chk("reset_in_ready", bus.in_ready, 1'b0);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_out_target", bus.out_target, 64'h0);
    chk("reset_cnt", mispredict_cnt, 32'h0);
    @(posedge clk); #1; reset = 0;

    // beq taken against a not-taken prediction
    drive(4'd3, 64'd5, 64'd5, 64'h100, 64'h20, 1'b0, 64'h0);
    bus.in_valid = 1; bus.out_ready = 1; lookup_pc = 64'h100;
    cycle();
    chk("beq_valid", bus.out_valid, 1'b1);
    chk("beq_taken", bus.out_taken, 1'b1);
    chk("beq_target", bus.out_target, 64'h120);
    chk("beq_mis", bus.out_mispredict, 1'b1);
    #1 chk("beq_lookup", lookup_taken, 1'b1);

    // jalr aligns its target and leaves the BHT alone
    drive(4'd2, 64'h1001, 64'd0, 64'h100, 64'h10, 1'b1, 64'h1010);
    cycle();
    chk("jalr_target", bus.out_target, 64'h1010);
    chk("jalr_mis", bus.out_mispredict, 1'b0);
    chk("jalr_cnt", mispredict_cnt, 32'd1);
    chk("jalr_lookup", lookup_taken, 1'b1);

    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].imm, vecs[i].pt, vecs[i].ptg);
      cycle();
      chk("vec_taken", bus.out_taken, vecs[i].et);
      chk("vec_target", bus.out_target, vecs[i].etg);
      chk("vec_mis", bus.out_mispredict, vecs[i].em);
    end

    // backpressure: result held while a second operand set waits
    drive(4'd4, 64'd1, 64'd2, 64'h600, 64'h80, 1'b0, 64'h0);
    cycle();
    saved_cnt = m_cnt;
    drive(4'd1, 64'd0, 64'd0, 64'h700, 64'h10, 1'b1, 64'h710);
    bus.out_ready = 0;
    repeat (3) begin
      cycle();
      chk("hold_ready", bus.in_ready, 1'b0);
      chk("hold_target", bus.out_target, 64'h680);
      chk("hold_mis", bus.out_mispredict, 1'b1);
    end
    bus.out_ready = 1;
    cycle();
    chk("second_target", bus.out_target, 64'h710);
    chk("second_cnt", mispredict_cnt, saved_cnt + 32'd1);
    bus.in_valid = 0;
    cycle();

    // counter saturation at one index
    lookup_pc = 64'h800; bus.in_valid = 1;
    drive(4'd3, 64'd9, 64'd9, 64'h800, 64'h4, 1'b1, 64'h804);
    repeat (4) cycle();
    chk("sat_lookup_hi", lookup_taken, 1'b1);
    drive(4'd3, 64'd9, 64'd8, 64'h800, 64'h4, 1'b1, 64'h804);
    repeat (2) cycle();
    chk("sat_lookup_lo", lookup_taken, 1'b0);

    // flush with a held mispredict and a new operand set
    lookup_pc = 64'h900;
    drive(4'd3, 64'd1, 64'd1, 64'h900, 64'h10, 1'b0, 64'h0);
    cycle();
    saved_cnt = m_cnt;
    saved_look = (m_bht[6'h0] >= 2);
    flush = 1;
    cycle();
    flush = 0; bus.in_valid = 0;
    chk("flush_valid", bus.out_valid, 1'b0);
    chk("flush_cnt", mispredict_cnt, saved_cnt);
    #1 chk("flush_lookup", lookup_taken, saved_look);
    cycle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin a = 64'($urandom_range(0, 7)) - 64'd3; b = 64'($urandom_range(0, 7)) - 64'd3; end
      drive(4'($urandom_range(0, 15)), a, b, {32'h0, $urandom_range(0, 255), 2'b00} & 64'h3FC,
            ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 64)) : {$urandom, $urandom},
            1'($urandom_range(0, 1)), {$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) bus.pred_target = bus.pc + bus.imm;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 9) == 0);
      lookup_pc     = {32'h0, 22'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), 2'b00} | 64'(2'($urandom_range(0, 3)));
      lookup_pc     = 64'($urandom_range(0, 255)) << 2;
      cycle();
    end
    flush = 0;

    // reset while a result is held
    drive(4'd5, 64'd1, 64'd2, 64'h100, 64'h8, 1'b0, 64'h0);
    bus.in_valid = 1; bus.out_ready = 0;
    cycle();
    reset = 1;
    #2;
    model_reset();
    chk("midrst_valid", bus.out_valid, 1'b0);
    chk("midrst_ready", bus.in_ready, 1'b0);
    chk("midrst_cnt", mispredict_cnt, 32'h0);
    @(posedge clk); #1; reset = 0;
    bus.out_ready = 1; lookup_pc = 64'h100;
    cycle();
    chk("postrst_target", bus.out_target, 64'h108);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
